rle_flash_reader: RTL and testbench
===================================

# rle_flash_reader

Streams the compressed RLE image from an external QSPI flash and presents it as 16-bit words to the RLE video decoder directly downstream. Issues one Quad Output Fast Read (0x6B) from a fixed start address, assembles nibbles into words, and buffers up to two words so the decoder can consume one word per cycle in bursts. The decoder's `stop_data` output aborts and rewinds the stream.

## Interface
- `START_ADDR`, default 24'h000000: flash byte address of the first RLE word.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `stop_data`  in  1  from decoder; abort the current read, flush, rewind to `START_ADDR`.
- `read_next`  in  1  from decoder; current head word consumed.
- `data_ready`  out  1  head word valid.
- `data`  out  16  head word.
- `spi_cs_n`  out  1  flash chip select.
- `spi_clk`  out  1  flash clock, max clk/2.
- `spi_d_out`  out  4  flash IO outputs.
- `spi_d_oe`  out  4  per-IO output enable.
- `spi_d_in`  in  4  flash IO inputs.

## Operation
- Reset values: `spi_cs_n`=1, `spi_clk`=0, `spi_d_out`=0, `spi_d_oe`=0, `data_ready`=0, `data`=0, buffer empty, state IDLE.
- States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DUMMY (8 clocks) -> DATA; DATA <-> STALL.
- IDLE: `spi_cs_n`=1. Leaves for CMD on the first cycle with `stop_data`=0, provided `spi_cs_n` has been high for at least 2 cycles.
- CMD/ADDR: single-line MSB-first on IO0, `spi_d_oe`=4'b0001; command 8'h6B, then `START_ADDR`.
- DUMMY: `spi_d_oe`=0, 8 SPI clocks, nothing sampled.
- DATA: 4 nibbles per word, first nibble -> `data[15:12]`, last -> `data[3:0]`. This matches the flash byte order: byte at the even address is the upper byte.
- Buffer: 2-entry FIFO. `data`/`data_ready` show the head. A completed word is pushed; `read_next` with `data_ready`=1 pops. `read_next` with `data_ready`=0 is ignored.
- Simultaneous push and pop: both take effect, occupancy unchanged.
- Flow control: DATA enters STALL at a word boundary when the words in the FIFO plus the word being shifted would exceed 2. STALL holds `spi_clk`=0 and CS low, and returns to DATA when a slot frees. There is no mid-word stall.
- `stop_data`=1 in any state: the next edge forces IDLE, `spi_cs_n`=1, `spi_clk`=0, `spi_d_oe`=0, FIFO flushed, `data_ready`=0, partial word discarded. `stop_data` outranks `read_next` and push.
- The stream never ends on its own. Addresses past flash end wrap inside the device.

## Timing
- Each SPI clock is 2 clk cycles.
- Outputs change on the cycle `spi_clk` goes 0. `spi_d_in` is sampled on the edge where registered `spi_clk` goes 1->0, i.e. the value present while `spi_clk` was high.
- First-word latency: `data_ready` rises exactly 89 cycles after the first IDLE cycle that sees `stop_data`=0 with the CS-high condition met. Breakdown: 1 CS setup + 16 CMD + 48 ADDR + 16 DUMMY + 8 DATA.
- Sustained throughput: 1 word per 8 cycles. The decoder may pop on the same cycle `data_ready` rises.
- `data_ready`/`data` are registered; after a pop, the next entry appears the following cycle.
- Reset mid-transfer: identical to `stop_data`, plus all outputs take their reset values.

## Structure
- Package `rle_pkg`:
  - `flash_state_t` enum (IDLE, CMD, ADDR, DUMMY, DATA, STALL).
  - `FLASH_CMD_QREAD`=8'h6B.
  - Bit counts `CMD_BITS`=8, `ADDR_BITS`=24, `DUMMY_CLKS`=8, `NIBBLES_PER_WORD`=4.
- Sub-module `rle_word_fifo`: 2-deep, 16-bit, push/pop/flush, valid/head outputs.
- The SPI sequencer and nibble shifter stay in this module.

## Test plan
- Reset then `stop_data`=0, flash model returns 16'h0842, 16'hFFC1: CS falls on cycle 1, IO0 shows 0x6B then 0x000000; `data_ready` at cycle 89 with `data`=16'h0842, then 16'hFFC1 eight cycles later.
- Decoder never pops: after 2 words, `spi_clk` is held 0 with CS low. One pop resumes the clock, and the third word appears 8 cycles after the pop.
- Pop on every cycle `data_ready`=1: 100 consecutive words match the flash model in order, with no duplicates or drops.
- `stop_data` pulsed while in DATA with 1 word buffered: the next cycle has `data_ready`=0 and `spi_cs_n`=1. The restart re-reads `START_ADDR`, and the first word again equals 16'h0842.
- Push and pop in the same cycle with 1 entry: occupancy stays 1 and the head becomes the new word.
- `START_ADDR`=24'h100000: address phase shows 0x100000, and data comes from the model at that offset.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE flash reader.
//   flash_state_t    : QSPI read sequencer states
//   FLASH_CMD_QREAD  : Quad Output Fast Read opcode
//   *_BITS / *_CLKS  : phase lengths in SPI clocks
package rle_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, STALL} flash_state_t;

  localparam logic [7:0] FLASH_CMD_QREAD  = 8'h6B;
  localparam int         CMD_BITS         = 8;
  localparam int         ADDR_BITS        = 24;
  localparam int         DUMMY_CLKS       = 8;
  localparam int         NIBBLES_PER_WORD = 4;
  localparam int         WORD_W           = 16;
endpackage

// File: rtl/rle_word_fifo.sv
// Two-entry word FIFO between the nibble shifter and the decoder.
//   clk, rstn  : clock, synchronous active-low reset
//   flush      : empties the FIFO (wins over push/pop)
//   push, din  : write a completed word
//   pop        : drop the head (ignored when empty)
//   valid/head : registered head entry
//   count      : occupancy 0..2
module rle_word_fifo
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic              valid,
  output logic [WORD_W-1:0] head,
  output logic [1:0]        count
);
  logic [WORD_W-1:0] r_mem0, r_mem1;
  logic [1:0]        r_cnt;
  logic              w_pop, w_push;

  assign w_pop  = pop && (r_cnt != 2'd0);
  assign w_push = push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_cnt  <= 2'd0;
      r_mem0 <= '0;
      r_mem1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_mem0 <= din;
          else               r_mem1 <= din;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; with one entry the new word becomes the head
          if (r_cnt == 2'd1) r_mem0 <= din;
          else begin
            r_mem0 <= r_mem1;
            r_mem1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (r_cnt != 2'd0);
  assign head  = r_mem0;
  assign count = r_cnt;
endmodule

// File: rtl/rle_flash_reader.sv
// Streams RLE words from a QSPI flash (single 0x6B read from START_ADDR)
// into a 2-word FIFO read by the RLE decoder.
//   clk, rstn            : clock, synchronous active-low reset
//   stop_data            : abort, flush and rewind to START_ADDR
//   read_next            : decoder consumed the head word
//   data_ready, data     : FIFO head
//   spi_cs_n, spi_clk    : flash select / clock (clk/2)
//   spi_d_out, spi_d_oe  : flash IO drive and enables
//   spi_d_in             : flash IO inputs
module rle_flash_reader
  import rle_pkg::*;
#(
  parameter logic [23:0] START_ADDR = 24'h000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stop_data,
  input  logic        read_next,
  output logic        data_ready,
  output logic [15:0] data,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic [3:0]  spi_d_out,
  output logic [3:0]  spi_d_oe,
  input  logic [3:0]  spi_d_in
);
  flash_state_t r_state, w_state_nxt;
  logic        r_sclk;
  logic [4:0]  r_cnt;      // SPI clocks (or nibbles) completed in the phase
  logic [31:0] r_sh;       // command + address, MSB out first
  logic [11:0] r_word;     // first three nibbles of the word in flight
  logic [1:0]  r_cshi;     // consecutive CS-high cycles, saturating at 2
  logic        w_cnt_last, w_push, w_pop;
  logic [1:0]  w_count, w_occ_nxt;
  logic [15:0] w_word;

  assign w_pop     = read_next && data_ready;
  // r_sclk high means this edge is an SPI falling edge: sample point
  assign w_push    = (r_state == DATA) && r_sclk && w_cnt_last;
  assign w_word    = {r_word, spi_d_in};
  assign w_occ_nxt = w_count + 2'd1 - {1'b0, w_pop};

  always_comb begin
    w_cnt_last = 1'b0;
    case (r_state)
      CMD:     w_cnt_last = (r_cnt == 5'(CMD_BITS - 1));
      ADDR:    w_cnt_last = (r_cnt == 5'(ADDR_BITS - 1));
      DUMMY:   w_cnt_last = (r_cnt == 5'(DUMMY_CLKS - 1));
      DATA:    w_cnt_last = (r_cnt == 5'(NIBBLES_PER_WORD - 1));
      default: w_cnt_last = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state
  always_comb begin
    w_state_nxt = r_state;
    if (stop_data) w_state_nxt = IDLE;
    else begin
      case (r_state)
        IDLE:    if (r_cshi == 2'd2)          w_state_nxt = CMD;
        CMD:     if (r_sclk && w_cnt_last)    w_state_nxt = ADDR;
        ADDR:    if (r_sclk && w_cnt_last)    w_state_nxt = DUMMY;
        DUMMY:   if (r_sclk && w_cnt_last)    w_state_nxt = DATA;
        // stall when the word about to start would not fit
        DATA:    if (w_push && (w_occ_nxt == 2'd2)) w_state_nxt = STALL;
        STALL:   if ((w_count != 2'd2) || w_pop) w_state_nxt = DATA;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    spi_cs_n  = (r_state == IDLE);
    spi_clk   = r_sclk;
    spi_d_oe  = 4'b0000;
    spi_d_out = 4'b0000;
    if ((r_state == CMD) || (r_state == ADDR)) begin
      spi_d_oe  = 4'b0001;
      spi_d_out = {3'b000, r_sh[31]};
    end
  end

  // SPI sequencer and nibble shifter
  always_ff @(posedge clk) begin
    if (!rstn || stop_data) begin
      r_sclk <= 1'b0;
      r_cnt  <= '0;
      r_sh   <= '0;
      r_word <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_state_nxt == CMD) r_sh <= {FLASH_CMD_QREAD, START_ADDR};
        CMD, ADDR, DUMMY, DATA: begin
          r_sclk <= ~r_sclk;
          if (r_sclk) begin
            r_cnt <= w_cnt_last ? 5'd0 : r_cnt + 5'd1;
            r_sh  <= r_sh << 1;
            if (r_state == DATA) r_word <= {r_word[7:0], spi_d_in};
          end
        end
        // the stall already served as the low phase: resume straight to high
        STALL: if (w_state_nxt == DATA) r_sclk <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)        r_cshi <= 2'd0;
    else if (spi_cs_n) r_cshi <= (r_cshi == 2'd2) ? 2'd2 : r_cshi + 2'd1;
    else              r_cshi <= 2'd0;
  end

  rle_word_fifo u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (stop_data),
    .push  (w_push),
    .pop   (read_next),
    .din   (w_word),
    .valid (data_ready),
    .head  (data),
    .count (w_count)
  );
endmodule

// File: tb/tb_rle_flash_reader.sv
module tb_rle_flash_reader;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic stop_data = 1'b1;
  logic read_next = 1'b0;
  logic [1:0]       rdy, sclk, csn;
  logic [1:0][15:0] dat;
  logic [1:0][3:0]  dout, oe;
  logic [1:0][3:0]  din = '0;

  localparam logic [23:0] BASE0 = 24'h000000;
  localparam logic [23:0] BASE1 = 24'h100000;

  int n_chk = 0, n_fail = 0, cyc = 0, nidx = 0;
  logic [7:0] seed;

  always #5 clk = ~clk;

  rle_flash_reader #(.START_ADDR(BASE0)) u0 (
    .clk(clk), .rstn(rstn), .stop_data(stop_data), .read_next(read_next),
    .data_ready(rdy[0]), .data(dat[0]), .spi_cs_n(csn[0]), .spi_clk(sclk[0]),
    .spi_d_out(dout[0]), .spi_d_oe(oe[0]), .spi_d_in(din[0]));
  rle_flash_reader #(.START_ADDR(BASE1)) u1 (
    .clk(clk), .rstn(rstn), .stop_data(stop_data), .read_next(read_next),
    .data_ready(rdy[1]), .data(dat[1]), .spi_cs_n(csn[1]), .spi_clk(sclk[1]),
    .spi_d_out(dout[1]), .spi_d_oe(oe[1]), .spi_d_in(din[1]));

  // flash contents: fixed head, pseudo-random elsewhere
  function automatic logic [7:0] byte_at(input logic [23:0] a);
    logic [31:0] t;
    case (a)
      24'd0: return 8'h08;
      24'd1: return 8'h42;
      24'd2: return 8'hFF;
      24'd3: return 8'hC1;
      default: begin
        t = a * 32'd151 + {24'd0, a[15:8]} * 32'd7 + {24'd0, a[23:16]};
        return t[7:0] ^ seed;
      end
    endcase
  endfunction

  function automatic logic [15:0] word_at(input logic [23:0] a);
    return {byte_at(a), byte_at(a + 24'd1)};
  endfunction

  function automatic logic [3:0] nib_at(input logic [23:0] base, input int k);
    logic [7:0] b;
    b = byte_at(base + 24'(k >> 1));
    return k[0] ? b[3:0] : b[7:4];
  endfunction

  // flash model: counts SPI rising edges, captures cmd/addr on IO0,
  // drives one nibble per falling edge once 8+24+8 clocks have passed
  int         rcnt[2];
  int         fn[2];
  logic [7:0] cap_cmd[2];
  logic [23:0] cap_addr[2];
  logic [1:0] prev_sclk = 2'b00;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (csn[u]) begin
        rcnt[u] <= 0;
        fn[u]   <= 0;
      end else if (sclk[u] && !prev_sclk[u]) begin
        rcnt[u] <= rcnt[u] + 1;
        if (rcnt[u] < 8)       cap_cmd[u]  <= {cap_cmd[u][6:0], dout[u][0]};
        else if (rcnt[u] < 32) cap_addr[u] <= {cap_addr[u][22:0], dout[u][0]};
      end else if (!sclk[u] && prev_sclk[u] && rcnt[u] >= 40) begin
        din[u] <= nib_at(u == 0 ? BASE0 : BASE1, fn[u]);
        fn[u]  <= fn[u] + 1;
      end
      prev_sclk[u] <= sclk[u];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // pop check: the head consumed this cycle must be the next stream word
  task automatic pop_check();
    if (read_next && rdy[0]) begin
      chk("stream0", {16'd0, dat[0]}, {16'd0, word_at(BASE0 + 24'(2 * nidx))});
      chk("stream1", {16'd0, dat[1]}, {16'd0, word_at(BASE1 + 24'(2 * nidx))});
      chk("ready1",  {31'd0, rdy[1]}, 32'd1);
      nidx++;
    end
  endtask

  initial begin
    int rc;
    seed = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      rcnt[i] = 0; fn[i] = 0; cap_cmd[i] = '0; cap_addr[i] = '0;
    end

    // reset values
    repeat (3) tick();
    chk("rst_cs_n",  {31'd0, csn[0]},  32'd1);
    chk("rst_clk",   {31'd0, sclk[0]}, 32'd0);
    chk("rst_dout",  {28'd0, dout[0]}, 32'd0);
    chk("rst_oe",    {28'd0, oe[0]},   32'd0);
    chk("rst_ready", {31'd0, rdy[0]},  32'd0);
    chk("rst_data",  {16'd0, dat[0]},  32'd0);

    // CS held high for several cycles, then start: this cycle is cycle 0
    rstn = 1'b1;
    repeat (4) tick();
    stop_data = 1'b0;
    cyc = 0;
    chk("c0_cs_high", {31'd0, csn[0]}, 32'd1);
    tick();
    chk("c1_cs_low", {31'd0, csn[0]}, 32'd0);
    chk("c1_oe",     {28'd0, oe[0]},  32'd1);
    while (cyc < 88) begin
      tick();
      if (cyc == 40) chk("addr_oe",  {28'd0, oe[0]}, 32'd1);
      if (cyc == 70) chk("dummy_oe", {28'd0, oe[0]}, 32'd0);
    end
    chk("c88_not_ready", {31'd0, rdy[0]}, 32'd0);
    tick();
    chk("c89_ready",  {31'd0, rdy[0]}, 32'd1);
    chk("c89_data",   {16'd0, dat[0]}, 32'h0842);
    chk("cmd0",       {24'd0, cap_cmd[0]}, 32'h6B);
    chk("addr0",      {8'd0, cap_addr[0]}, {8'd0, BASE0});
    chk("cmd1",       {24'd0, cap_cmd[1]}, 32'h6B);
    chk("addr1",      {8'd0, cap_addr[1]}, {8'd0, BASE1});
    chk("c89_ready1", {31'd0, rdy[1]}, 32'd1);
    chk("c89_data1",  {16'd0, dat[1]}, {16'd0, word_at(BASE1)});

    // no pops: two words buffered, then SPI clock parks low with CS low
    run_to(97);
    chk("c97_head", {16'd0, dat[0]}, 32'h0842);
    run_to(120);
    chk("stall_clk",   {31'd0, sclk[0]}, 32'd0);
    chk("stall_cs",    {31'd0, csn[0]},  32'd0);
    chk("stall_edges", rcnt[0], 32'd48);
    read_next = 1'b1;                      // pop at cycle 120
    tick();
    chk("resume_clk", {31'd0, sclk[0]}, 32'd1);
    chk("head_w1",    {16'd0, dat[0]},  32'hFFC1);
    tick();
    read_next = 1'b0;
    chk("empty_122", {31'd0, rdy[0]}, 32'd0);
    run_to(127);
    chk("empty_127", {31'd0, rdy[0]}, 32'd0);
    tick();
    chk("w2_ready", {31'd0, rdy[0]}, 32'd1);
    chk("w2_data",  {16'd0, dat[0]}, {16'd0, word_at(BASE0 + 24'd4)});

    // stop with one word buffered
    stop_data = 1'b1;
    tick();
    stop_data = 1'b0;
    chk("stop_ready", {31'd0, rdy[0]},  32'd0);
    chk("stop_cs",    {31'd0, csn[0]},  32'd1);
    chk("stop_clk",   {31'd0, sclk[0]}, 32'd0);
    chk("stop_oe",    {28'd0, oe[0]},   32'd0);
    rc = 0;
    while (!rdy[0] && rc < 200) begin
      tick();
      rc++;
    end
    chk("restart_ready", {31'd0, rdy[0]}, 32'd1);
    chk("restart_data",  {16'd0, dat[0]}, 32'h0842);
    chk("restart_addr",  {8'd0, cap_addr[0]}, {8'd0, BASE0});

    // push and pop together with one entry: w1 replaces w0 as head
    repeat (7) tick();
    read_next = 1'b1;
    tick();
    chk("pp_ready", {31'd0, rdy[0]}, 32'd1);
    chk("pp_head",  {16'd0, dat[0]}, 32'hFFC1);
    tick();
    read_next = 1'b0;
    chk("pp_occ1", {31'd0, rdy[0]}, 32'd0);

    // decoder pops every cycle: 100 words in order
    nidx = 2;
    rc = 0;
    while (nidx < 102 && rc < 3000) begin
      read_next = 1'b1;
      pop_check();
      tick();
      rc++;
    end
    chk("burst_words", nidx, 32'd102);

    // random pops
    for (int c = 0; c < 800; c++) begin
      read_next = 1'($urandom_range(0, 1));
      pop_check();
      tick();
    end
    read_next = 1'b0;
    chk("random_progress", {31'd0, 1'(nidx > 150)}, 32'd1);

    stop_data = 1'b1;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
